// File: rtl/tl_pkg.sv
// Shared constants for the traffic_light tick generator.
package tl_pkg;

    localparam int unsigned TL_DIV_DEFAULT = 100;
    localparam int unsigned TL_CNT_W       = 16;
    localparam int unsigned TL_SEC_W       = 8;
    localparam int unsigned TL_DIV_MIN     = 2;

endpackage

// File: rtl/tick_div_core.sv
// Prescale counter: counts enabled cycles and flags the last cycle of each period.
module tick_div_core
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W = TL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_cur,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // div_cur only changes on a wrap edge, so cnt never exceeds div_cur-1
    assign wrap = en && (cnt == div_cur - ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            if (wrap) cnt <= '0;
            else      cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick strobe generator with boundary-aligned divisor reload.
module tick_gen
    import tl_pkg::*;
#(
    parameter int unsigned DIV_DEFAULT = TL_DIV_DEFAULT,
    parameter int unsigned CNT_W       = TL_CNT_W,
    parameter int unsigned SEC_W       = TL_SEC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_busy,
    output logic             div_err,
    output logic [SEC_W-1:0] sec_cnt
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(TL_DIV_MIN);
    localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

    logic             wrap;
    logic             load_ok;
    logic [CNT_W-1:0] div_pend;

    assign load_ok = div_load && (div_val >= DIV_MIN);

    tick_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_cur (div_cur),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick     <= 1'b0;
            div_cur  <= DIV_RST;
            div_pend <= '0;
            div_busy <= 1'b0;
            div_err  <= 1'b0;
            sec_cnt  <= '0;
        end else begin
            tick    <= wrap;
            div_err <= div_load && !load_ok;
            if (wrap) sec_cnt <= sec_cnt + SEC_ONE;

            // A valid load landing on the wrap edge bypasses div_pend entirely
            if (wrap) begin
                div_busy <= 1'b0;
                if (load_ok)       div_cur <= div_val;
                else if (div_busy) div_cur <= div_pend;
            end else if (load_ok) begin
                div_pend <= div_val;
                div_busy <= 1'b1;
            end
        end
    end

endmodule
